// File: rtl/dr_regs.sv
// Front-panel display register: bus-writable 16-bit latch at 17570/17571, serialised MSB first to an LED shift chain.
// Writes land one edge after decode; frames take 33*CLKDIV cycles and writes during a frame coalesce into one follow-up frame.
module dr_regs #(
  parameter logic [12:0] DR_ADDR = 13'o17570,
  parameter int          CLKDIV  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] iopage_addr,
  input  logic [15:0] data_in,
  input  logic        iopage_rd,
  input  logic        iopage_wr,
  input  logic        iopage_byte_op,
  output logic        decode,
  output logic [15:0] dr_value,
  output logic        led_sclk,
  output logic        led_sdata,
  output logic        led_latch,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, LATCH} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLKDIV - 1);

  state_t      state;
  logic [15:0] shadow;
  logic [3:0]  bit_idx;
  logic [7:0]  div;
  logic        pending;
  logic        match;
  logic        wr_word;
  logic        wr_lo;
  logic        wr_hi;
  logic        div_done;
  logic        rd_unused;

  // Reads of 17570 belong to the switch register, so only writes select us.
  assign match     = (iopage_addr[12:1] == DR_ADDR[12:1]);
  assign decode    = match & iopage_wr;
  assign wr_word   = decode & ~iopage_byte_op;
  assign wr_lo     = decode & iopage_byte_op & ~iopage_addr[0];
  assign wr_hi     = decode & iopage_byte_op &  iopage_addr[0];
  assign div_done  = (div == DIV_LAST);
  assign rd_unused = iopage_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      dr_value  <= '0;
      shadow    <= '0;
      bit_idx   <= '0;
      div       <= '0;
      pending   <= 1'b1;
      led_sclk  <= 1'b0;
      led_sdata <= 1'b0;
      led_latch <= 1'b0;
      busy      <= 1'b0;
      state     <= IDLE;
    end else begin
      if (wr_word)
        dr_value <= data_in;
      else if (wr_lo)
        dr_value[7:0] <= data_in[7:0];
      else if (wr_hi)
        dr_value[15:8] <= data_in[15:8];

      // A write on the capture edge re-arms pending so a follow-up frame runs.
      if (decode)
        pending <= 1'b1;
      else if (state == IDLE && pending)
        pending <= 1'b0;

      case (state)
        IDLE: begin
          if (pending) begin
            shadow    <= dr_value;
            bit_idx   <= 4'd15;
            led_sdata <= dr_value[15];
            div       <= '0;
            busy      <= 1'b1;
            state     <= LOW;
          end
        end
        LOW: begin
          if (div_done) begin
            div      <= '0;
            led_sclk <= 1'b1;
            state    <= HIGH;
          end else begin
            div <= div + 8'd1;
          end
        end
        HIGH: begin
          if (div_done) begin
            div      <= '0;
            led_sclk <= 1'b0;
            if (bit_idx == 4'd0) begin
              led_sdata <= 1'b0;
              led_latch <= 1'b1;
              state     <= LATCH;
            end else begin
              bit_idx   <= bit_idx - 4'd1;
              led_sdata <= shadow[bit_idx - 4'd1];
              state     <= LOW;
            end
          end else begin
            div <= div + 8'd1;
          end
        end
        LATCH: begin
          if (div_done) begin
            div       <= '0;
            led_latch <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            div <= div + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dr_regs.sv
// Bench for dr_regs: expected frames queued as writes/resets are driven, compared as each serial frame completes.
module tb_dr_regs;
  localparam int CLKDIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [12:0] iopage_addr = '0;
  logic [15:0] data_in = '0;
  logic        iopage_rd = 1'b0;
  logic        iopage_wr = 1'b0;
  logic        iopage_byte_op = 1'b0;
  logic        decode;
  logic [15:0] dr_value;
  logic        led_sclk;
  logic        led_sdata;
  logic        led_latch;
  logic        busy;

  always #5 clk = ~clk;

  dr_regs #(.DR_ADDR(13'o17570), .CLKDIV(CLKDIV)) dut (
    .clk(clk), .reset(reset), .iopage_addr(iopage_addr), .data_in(data_in),
    .iopage_rd(iopage_rd), .iopage_wr(iopage_wr), .iopage_byte_op(iopage_byte_op),
    .decode(decode), .dr_value(dr_value), .led_sclk(led_sclk), .led_sdata(led_sdata),
    .led_latch(led_latch), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  logic [15:0] sb[$];

  // Frame monitor, sampled on the falling edge.
  int          frames_done = 0;
  int          rises = 0;
  int          latch_cnt = 0;
  int          latch_total = 0;
  int          busy_cnt = 0;
  int          low_run = 0;
  int          last_gap = -1;
  logic [15:0] bits = '0;
  logic        prev_sclk = 1'b0;
  logic        prev_busy = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      rises = 0; latch_cnt = 0; busy_cnt = 0; low_run = 0; bits = '0;
      prev_sclk = 1'b0; prev_busy = 1'b0;
    end else begin
      if (busy) begin
        if (!prev_busy) last_gap = low_run;
        busy_cnt++;
        low_run = 0;
      end else begin
        low_run++;
      end
      if (led_sclk && !prev_sclk) begin
        bits = {bits[14:0], led_sdata};
        rises++;
      end
      if (led_latch) begin
        latch_cnt++;
        latch_total++;
      end
      if (!busy && prev_busy) begin
        if (sb.size() == 0) check_val("sb_underflow", sb.size(), 1);
        else check_val("frame_data", bits, sb.pop_front());
        check_val("sclk_rises", rises, 16);
        check_val("latch_len", latch_cnt, CLKDIV);
        check_val("frame_len", busy_cnt, 33 * CLKDIV);
        frames_done++;
        rises = 0; latch_cnt = 0; busy_cnt = 0; bits = '0;
      end
      prev_sclk = led_sclk;
      prev_busy = busy;
    end
  end

  task automatic bus_write(input logic [12:0] a, input logic [15:0] d, input logic byte_op,
                           input logic [15:0] exp_val, input string tag);
    @(negedge clk);
    iopage_addr = a; data_in = d; iopage_wr = 1'b1; iopage_byte_op = byte_op;
    #1 check_val({tag, "_decode"}, decode, 1);
    @(negedge clk);
    iopage_wr = 1'b0; iopage_byte_op = 1'b0;
    check_val({tag, "_value"}, dr_value, exp_val);
  endtask

  task automatic wait_frames(input int n, input int budget);
    int cnt = 0;
    while (frames_done < n && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    check_val("frames_done", frames_done, n);
  endtask

  task automatic wait_busy(input int budget);
    int cnt = 0;
    while (!busy && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    check_val("busy_start", busy, 1);
  endtask

  initial begin
    int lt;
    int cnt;
    // Reset state and the power-up zero frame.
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy, 0);
    check_val("rst_value", dr_value, 0);
    check_val("rst_sclk", led_sclk, 0);
    check_val("rst_latch", led_latch, 0);
    sb.push_back(16'h0000);
    reset = 1'b0;
    @(negedge clk);
    check_val("busy_after_rst", busy, 1);
    wait_frames(1, 600);

    sb.push_back(16'hA5C3);
    bus_write(13'o17570, 16'hA5C3, 1'b0, 16'hA5C3, "word");
    wait_frames(2, 600);

    sb.push_back(16'h1234);
    bus_write(13'o17570, 16'h1234, 1'b0, 16'h1234, "w1234");
    wait_frames(3, 600);
    sb.push_back(16'hAB34);
    bus_write(13'o17571, 16'hAB00, 1'b1, 16'hAB34, "byte_hi");
    sb.push_back(16'hABCD);
    bus_write(13'o17570, 16'h00CD, 1'b1, 16'hABCD, "byte_lo");
    wait_frames(5, 900);

    // Two writes during one frame coalesce into a single follow-up frame.
    sb.push_back(16'h0F0F);
    bus_write(13'o17570, 16'h0F0F, 1'b0, 16'h0F0F, "w0f0f");
    wait_busy(10);
    bus_write(13'o17570, 16'h1111, 1'b0, 16'h1111, "w1111");
    bus_write(13'o17570, 16'h2222, 1'b0, 16'h2222, "w2222");
    sb.push_back(16'h2222);
    wait_frames(7, 900);
    check_val("busy_gap", last_gap, 1);

    // Non-matching write and a read must not touch the block.
    @(negedge clk);
    iopage_addr = 13'o17572; data_in = 16'hDEAD; iopage_wr = 1'b1;
    #1 check_val("other_addr_decode", decode, 0);
    @(negedge clk);
    iopage_wr = 1'b0; iopage_rd = 1'b1; iopage_addr = 13'o17570;
    #1 check_val("read_decode", decode, 0);
    @(negedge clk);
    iopage_rd = 1'b0;
    repeat (200) @(negedge clk);
    check_val("no_frame_frames", frames_done, 7);
    check_val("no_frame_busy", busy, 0);
    check_val("no_change_value", dr_value, 16'h2222);

    // Reset during the high phase of bit 7 aborts the frame.
    sb.push_back(16'hFFFF);
    bus_write(13'o17570, 16'hFFFF, 1'b0, 16'hFFFF, "wffff");
    cnt = 0;
    while (rises < 9 && cnt < 400) begin
      @(negedge clk);
      cnt++;
    end
    check_val("reach_bit7", rises, 9);
    check_val("bit7_sclk", led_sclk, 1);
    lt = latch_total;
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_sclk", led_sclk, 0);
    check_val("abort_sdata", led_sdata, 0);
    check_val("abort_latch", led_latch, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_no_latch", latch_total, lt);
    sb.delete();
    sb.push_back(16'h0000);
    @(negedge clk);
    reset = 1'b0;
    wait_frames(8, 600);
    check_val("post_rst_value", dr_value, 0);
    check_val("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
